sdf_r2_stage1: RTL and testbench

Final radix-2 single-path-delay-feedback (SDF) stage of the 32-point FFT pipeline. It sits directly downstream of the delay-2 (−j twiddle) butterfly stage. It registers that stage's combinational outputs, holds one complex sample in a 1-deep feedback delay, and emits sum and difference pairs; this stage applies no twiddle. Output is in bit-reversed frequency order, tagged with its natural bin index.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/sdf_r2_bf1.sv | 28 ++
 rtl/sdf_r2_stage1.sv | 124 ++++++++++++
 tb/tb_sdf_r2_stage1.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point SDF FFT pipeline: frame geometry,
// sample widths, stage FSM states and the bin-index bit reversal.
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int IN_W  = 17;
  localparam int OUT_W = IN_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_r2_bf1.sv
// Radix-2 butterfly core: sign-extends the new sample and forms
// new+delayed and delayed-new at full output width.
module sdf_r2_bf1 #(
  parameter int IN_W  = 17,
  parameter int OUT_W = IN_W + 1
) (
  input  logic signed [IN_W-1:0]  a_r,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [OUT_W-1:0] d_r,
  input  logic signed [OUT_W-1:0] d_i,
  output logic signed [OUT_W-1:0] ext_r,
  output logic signed [OUT_W-1:0] ext_i,
  output logic signed [OUT_W-1:0] sum_r,
  output logic signed [OUT_W-1:0] sum_i,
  output logic signed [OUT_W-1:0] diff_r,
  output logic signed [OUT_W-1:0] diff_i
);

  always_comb begin
    ext_r  = OUT_W'(a_r);
    ext_i  = OUT_W'(a_i);
    sum_r  = ext_r + d_r;
    sum_i  = ext_i + d_i;
    diff_r = d_r - ext_r;
    diff_i = d_i - ext_i;
  end

endmodule

// File: rtl/sdf_r2_stage1.sv
// Final radix-2 SDF stage: registers the upstream sample, pairs it through a
// 1-deep feedback delay and emits sum then difference in bit-reversed order.
module sdf_r2_stage1 #(
  parameter int N     = fft_pkg::N,
  parameter int IN_W  = fft_pkg::IN_W,
  parameter int OUT_W = IN_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_r,
  input  logic signed [IN_W-1:0]  in_i,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_r,
  output logic signed [OUT_W-1:0] out_i,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    frame_done
);

  import fft_pkg::*;

  localparam int LW = $clog2(N);

  logic                    a_vld;
  logic signed [IN_W-1:0]  a_r, a_i;
  logic signed [OUT_W-1:0] d_r, d_i;
  logic                    pend;
  state_t                  state;
  logic [LW-1:0]           in_cnt, out_cnt;

  logic signed [OUT_W-1:0] ext_r, ext_i, sum_r, sum_i, diff_r, diff_i;
  logic                    emit;
  logic signed [OUT_W-1:0] emit_r, emit_i;

  sdf_r2_bf1 #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_bf1 (
    .a_r    (a_r),
    .a_i    (a_i),
    .d_r    (d_r),
    .d_i    (d_i),
    .ext_r  (ext_r),
    .ext_i  (ext_i),
    .sum_r  (sum_r),
    .sum_i  (sum_i),
    .diff_r (diff_r),
    .diff_i (diff_i)
  );

  // A tail can never arrive while a difference is pending, so the two
  // output sources are mutually exclusive.
  always_comb begin
    emit   = 1'b0;
    emit_r = '0;
    emit_i = '0;
    if (state == TAIL && a_vld) begin
      emit   = 1'b1;
      emit_r = sum_r;
      emit_i = sum_i;
    end else if (pend) begin
      emit   = 1'b1;
      emit_r = d_r;
      emit_i = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld      <= 1'b0;
      a_r        <= '0;
      a_i        <= '0;
      d_r        <= '0;
      d_i        <= '0;
      pend       <= 1'b0;
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
      out_r      <= '0;
      out_i      <= '0;
      out_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      a_vld <= in_valid;
      a_r   <= in_r;
      a_i   <= in_i;

      if (pend) pend <= 1'b0;

      case (state)
        IDLE, HEAD: begin
          if (a_vld) begin
            d_r    <= ext_r;
            d_i    <= ext_i;
            in_cnt <= (state == IDLE) ? LW'(1) : in_cnt + LW'(1);
            state  <= TAIL;
          end
        end
        TAIL: begin
          if (a_vld) begin
            d_r    <= diff_r;
            d_i    <= diff_i;
            pend   <= 1'b1;
            in_cnt <= in_cnt + LW'(1);
            state  <= (in_cnt == LW'(N - 1)) ? IDLE : HEAD;
          end
        end
        default: state <= IDLE;
      endcase

      out_valid  <= emit;
      frame_done <= 1'b0;
      if (emit) begin
        out_r      <= emit_r;
        out_i      <= emit_i;
        out_idx    <= LW'(bit_reverse(32'(out_cnt), LW));
        out_cnt    <= (out_cnt == LW'(N - 1)) ? '0 : out_cnt + LW'(1);
        frame_done <= (out_cnt == LW'(N - 1));
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage1.sv
// Directed bench for sdf_r2_stage1: per-scenario tasks compare every cycle's
// outputs against hand-derived expected tables.
module tb_sdf_r2_stage1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [16:0] in_r = '0;
  logic signed [16:0] in_i = '0;
  logic               out_valid;
  logic signed [17:0] out_r, out_i;
  logic [4:0]         out_idx;
  logic               frame_done;

  sdf_r2_stage1 #(.N(32), .IN_W(17)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_r       (in_r),
    .in_i       (in_i),
    .out_valid  (out_valid),
    .out_r      (out_r),
    .out_i      (out_i),
    .out_idx    (out_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic               vv [128];
  logic signed [16:0] vr [128];
  logic signed [16:0] vi [128];

  logic               o_v [129];
  logic signed [17:0] o_r [129];
  logic signed [17:0] o_i [129];
  logic [4:0]         o_x [129];
  logic               o_f [129];

  logic               e_v [129];
  logic signed [17:0] e_r [129];
  logic signed [17:0] e_i [129];
  logic [4:0]         e_x [129];
  logic               e_f [129];

  function automatic logic [4:0] rev5(input int j);
    logic [4:0] b;
    b = 5'(j);
    return {b[0], b[1], b[2], b[3], b[4]};
  endfunction

  task automatic clear_tables();
    for (int k = 0; k < 128; k++) begin
      vv[k] = 1'b0; vr[k] = '0; vi[k] = '0;
    end
    for (int k = 0; k < 129; k++) begin
      e_v[k] = 1'b0; e_r[k] = '0; e_i[k] = '0; e_x[k] = '0; e_f[k] = 1'b0;
    end
  endtask

  task automatic expect_out(input int c, input int r, input int i, input int j);
    e_v[c] = 1'b1;
    e_r[c] = 18'(r);
    e_i[c] = 18'(i);
    e_x[c] = rev5(j);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic record(input int c);
    o_v[c] = out_valid; o_r[c] = out_r; o_i[c] = out_i;
    o_x[c] = out_idx;   o_f[c] = frame_done;
  endtask

  // Applies vv/vr/vi at cycles 0..m-1; o_*[c] holds outputs seen in cycle c.
  task automatic run(input int m);
    record(0);
    for (int k = 0; k < m; k++) begin
      in_valid = vv[k]; in_r = vr[k]; in_i = vi[k];
      @(posedge clk);
      #1 record(k + 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({out_valid, out_r, out_i, out_idx, frame_done} !== '0) begin
      n_err++;
      $display("FAIL reset_init got v=%b r=%0d i=%0d idx=%0d fd=%b required all 0",
               out_valid, out_r, out_i, out_idx, frame_done);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_r = 17'(k + 1); in_i = 17'(k + 1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    in_r = 17'(999); in_i = 17'(-999);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_r, out_i, out_idx, frame_done} !== '0) begin
        n_err++;
        $display("FAIL reset_mid cyc=%0d got v=%b r=%0d i=%0d idx=%0d fd=%b required all 0",
                 k, out_valid, out_r, out_i, out_idx, frame_done);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    clear_tables();
    vv[0] = 1'b1; vr[0] = 17'(7); vi[0] = 17'(1);
    vv[1] = 1'b1; vr[1] = 17'(3); vi[1] = 17'(2);
    expect_out(3, 10, 3, 0);
    expect_out(4, 4, -1, 1);
    run(7);
    for (int c = 0; c <= 7; c++) begin
      n_cmp++;
      if (o_v[c] !== e_v[c] || (e_v[c] && {o_r[c], o_i[c], o_x[c]} !== {e_r[c], e_i[c], e_x[c]})) begin
        n_err++;
        $display("FAIL reset_restart c=%0d got v=%b (%0d,%0d) idx=%0d required v=%b (%0d,%0d) idx=%0d",
                 c, o_v[c], o_r[c], o_i[c], o_x[c], e_v[c], e_r[c], e_i[c], e_x[c]);
      end
    end
  endtask

  task automatic test_single_pair();
    do_reset();
    clear_tables();
    vv[0] = 1'b1; vr[0] = 17'(100); vi[0] = 17'(-50);
    vv[1] = 1'b1; vr[1] = 17'(20);  vi[1] = 17'(30);
    expect_out(3, 120, -20, 0);
    expect_out(4, 80, -80, 1);
    run(8);
    for (int c = 0; c <= 8; c++) begin
      n_cmp++;
      if (o_v[c] !== e_v[c] || (e_v[c] && {o_r[c], o_i[c], o_x[c]} !== {e_r[c], e_i[c], e_x[c]})) begin
        n_err++;
        $display("FAIL single_pair c=%0d got v=%b (%0d,%0d) idx=%0d required v=%b (%0d,%0d) idx=%0d",
                 c, o_v[c], o_r[c], o_i[c], o_x[c], e_v[c], e_r[c], e_i[c], e_x[c]);
      end
      n_cmp++;
      if (o_f[c] !== 1'b0) begin
        n_err++;
        $display("FAIL single_pair_fd c=%0d got %b required 0", c, o_f[c]);
      end
    end
  endtask

  // Ramp s_k=(k,-k) over nframes frames back to back; output j is the
  // pair sum (2j+1,-(2j+1)) when j is even and (-1,1) when odd.
  task automatic test_frames(input int nframes, input string name);
    int ns;
    ns = 32 * nframes;
    do_reset();
    clear_tables();
    for (int k = 0; k < ns; k++) begin
      vv[k] = 1'b1; vr[k] = 17'(k); vi[k] = 17'(-k);
    end
    for (int j = 0; j < ns; j++) begin
      if (j % 2 == 0) expect_out(j + 3, 2 * j + 1, -(2 * j + 1), j);
      else            expect_out(j + 3, -1, 1, j);
    end
    for (int f = 1; f <= nframes; f++) e_f[32 * f + 2] = 1'b1;
    run(ns + 6);
    for (int c = 0; c <= ns + 6; c++) begin
      n_cmp++;
      if (o_v[c] !== e_v[c] || (e_v[c] && {o_r[c], o_i[c], o_x[c]} !== {e_r[c], e_i[c], e_x[c]})) begin
        n_err++;
        $display("FAIL %s c=%0d got v=%b (%0d,%0d) idx=%0d required v=%b (%0d,%0d) idx=%0d",
                 name, c, o_v[c], o_r[c], o_i[c], o_x[c], e_v[c], e_r[c], e_i[c], e_x[c]);
      end
      n_cmp++;
      if (o_f[c] !== e_f[c]) begin
        n_err++;
        $display("FAIL %s_fd c=%0d got %b required %b", name, c, o_f[c], e_f[c]);
      end
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    clear_tables();
    vv[0] = 1'b1; vr[0] = 17'(10); vi[0] = 17'(20);
    vv[4] = 1'b1; vr[4] = 17'(4);  vi[4] = 17'(-6);
    vv[8] = 1'b1; vr[8] = 17'(1);  vi[8] = 17'(2);
    vv[9] = 1'b1; vr[9] = 17'(3);  vi[9] = 17'(5);
    expect_out(6, 14, 14, 0);
    expect_out(7, 6, 26, 1);
    expect_out(11, 4, 7, 2);
    expect_out(12, -2, -3, 3);
    run(15);
    for (int c = 0; c <= 15; c++) begin
      n_cmp++;
      if (o_v[c] !== e_v[c] || (e_v[c] && {o_r[c], o_i[c], o_x[c]} !== {e_r[c], e_i[c], e_x[c]})) begin
        n_err++;
        $display("FAIL bubbles c=%0d got v=%b (%0d,%0d) idx=%0d required v=%b (%0d,%0d) idx=%0d",
                 c, o_v[c], o_r[c], o_i[c], o_x[c], e_v[c], e_r[c], e_i[c], e_x[c]);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    clear_tables();
    vv[0] = 1'b1; vr[0] = 17'(-65536); vi[0] = 17'(65535);
    vv[1] = 1'b1; vr[1] = 17'(-65536); vi[1] = 17'(65535);
    expect_out(3, -131072, 131070, 0);
    expect_out(4, 0, 0, 1);
    run(6);
    for (int c = 0; c <= 6; c++) begin
      n_cmp++;
      if (o_v[c] !== e_v[c] || (e_v[c] && {o_r[c], o_i[c], o_x[c]} !== {e_r[c], e_i[c], e_x[c]})) begin
        n_err++;
        $display("FAIL extremes c=%0d got v=%b (%0d,%0d) idx=%0d required v=%b (%0d,%0d) idx=%0d",
                 c, o_v[c], o_r[c], o_i[c], o_x[c], e_v[c], e_r[c], e_i[c], e_x[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_frames(1, "full_frame");
    test_bubbles();
    test_extremes();
    test_frames(2, "back_to_back");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
